// File: rtl/cp0_except_ctrl.sv
// Exception/interrupt sequencer between the MEM stage and the CP0 register file.
// Captures one event, writes EPC/CAUSE/STATUS over successive cycles, then redirects fetch.
module cp0_except_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [4:0]  ADDR_STATUS = 5'd3,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd4,
  parameter logic [4:0]  ADDR_EPC    = 5'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        redirect_o,
  output logic [31:0] new_pc_o,
  output logic [4:0]  exc_code_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_EPC,
    S_WR_CAUSE,
    S_WR_STATUS,
    S_REDIRECT
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_pc;
  logic        r_bd;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic        r_eret;
  logic [31:0] r_new_pc;

  logic [5:0]  w_ip;
  logic        w_int_pend;
  logic        w_event;
  logic        w_is_eret;
  logic [4:0]  w_code;
  logic        w_capture;
  logic [31:0] w_cause_data;
  logic        w_unused_bits;

  assign w_unused_bits = ^{excepttype_i[31:13], excepttype_i[7:0]};

  assign w_ip       = {int_i[5] | timer_int_i, int_i[4:0]};
  assign w_int_pend = ((w_ip & status_i[15:10]) != 6'd0) && status_i[0] && !status_i[1];

  // Fixed priority: interrupt, syscall, invalid, trap, overflow, eret
  always_comb begin
    w_code    = 5'd0;
    w_is_eret = 1'b0;
    w_event   = 1'b1;
    if (w_int_pend)            w_code = 5'd0;
    else if (excepttype_i[8])  w_code = 5'd8;
    else if (excepttype_i[9])  w_code = 5'd10;
    else if (excepttype_i[10]) w_code = 5'd13;
    else if (excepttype_i[11]) w_code = 5'd12;
    else if (excepttype_i[12]) w_is_eret = 1'b1;
    else                       w_event = 1'b0;
  end

  assign w_capture = (r_state == S_IDLE) && valid_i && w_event;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= 32'd0;
      r_bd       <= 1'b0;
      r_status   <= 32'd0;
      r_cause    <= 32'd0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_eret     <= 1'b0;
      r_new_pc   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_pc       <= pc_i;
        r_bd       <= in_delayslot_i;
        r_status   <= status_i;
        r_cause    <= cause_i;
        r_ip       <= w_ip;
        r_exc_code <= w_code;
        r_eret     <= w_is_eret;
        r_new_pc   <= w_is_eret ? epc_i : EXC_VECTOR;
      end
    end
  end

  // A nested exception (EXL already set) keeps the original BD flag
  always_comb begin
    w_cause_data        = r_cause;
    w_cause_data[15:10] = r_ip;
    w_cause_data[6:2]   = r_exc_code;
    if (!r_status[1]) w_cause_data[31] = r_bd;
  end

  always_comb begin
    w_next      = r_state;
    cp0_we_o    = 1'b0;
    cp0_waddr_o = 5'd0;
    cp0_data_o  = 32'd0;
    redirect_o  = 1'b0;
    flush_o     = (r_state != S_IDLE);
    busy_o      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_next = w_is_eret ? S_WR_STATUS : S_WR_EPC;
      end
      S_WR_EPC: begin
        if (!r_status[1]) begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = ADDR_EPC;
          cp0_data_o  = r_bd ? (r_pc - 32'd4) : r_pc;
        end
        w_next = S_WR_CAUSE;
      end
      S_WR_CAUSE: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_CAUSE;
        cp0_data_o  = w_cause_data;
        w_next      = S_WR_STATUS;
      end
      S_WR_STATUS: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_data_o  = r_eret ? (r_status & ~32'h2) : (r_status | 32'h2);
        w_next      = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_o = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign new_pc_o   = r_new_pc;
  assign exc_code_o = r_exc_code;

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Self-checking bench for cp0_except_ctrl: directed scenarios plus randomized
// events checked against a rule-level reference model.
module tb_cp0_except_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] excepttype_i = '0;
  logic [31:0] pc_i = '0;
  logic        in_delayslot_i = 1'b0;
  logic [5:0]  int_i = '0;
  logic        timer_int_i = 1'b0;
  logic [31:0] status_i = '0;
  logic [31:0] cause_i = '0;
  logic [31:0] epc_i = '0;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_data_o;
  logic        flush_o;
  logic        busy_o;
  logic        redirect_o;
  logic [31:0] new_pc_o;
  logic [4:0]  exc_code_o;

  int n_checks = 0;
  int n_errors = 0;

  logic        obs_busy  [1:5];
  logic        obs_flush [1:5];
  logic        obs_redir [1:5];
  logic        obs_we    [1:5];
  logic [4:0]  obs_addr  [1:5];
  logic [31:0] obs_data  [1:5];
  logic [31:0] obs_pc    [1:5];
  logic [4:0]  obs_code  [1:5];

  cp0_except_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .excepttype_i(excepttype_i),
    .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .int_i(int_i),
    .timer_int_i(timer_int_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o),
    .cp0_data_o(cp0_data_o), .flush_o(flush_o), .busy_o(busy_o),
    .redirect_o(redirect_o), .new_pc_o(new_pc_o), .exc_code_o(exc_code_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] et, input logic [31:0] pc,
                       input logic bd, input logic [5:0] intl, input logic tmr,
                       input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
    valid_i = v; excepttype_i = et; pc_i = pc; in_delayslot_i = bd;
    int_i = intl; timer_int_i = tmr; status_i = st; cause_i = ca; epc_i = ep;
  endtask

  // Records outputs for the five cycles following the capture edge; inputs
  // are scrambled while busy to confirm they are ignored.
  task automatic run_event(input bit junk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      obs_busy[k] = busy_o;   obs_flush[k] = flush_o; obs_redir[k] = redirect_o;
      obs_we[k]   = cp0_we_o; obs_addr[k]  = cp0_waddr_o; obs_data[k] = cp0_data_o;
      obs_pc[k]   = new_pc_o; obs_code[k]  = exc_code_o;
      if (k == 1 && junk)
        drive(1'b1, $urandom, $urandom, 1'($urandom), 6'($urandom), 1'($urandom),
              $urandom, $urandom, $urandom);
      if (k == 2) valid_i = 1'b0;
    end
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({cp0_we_o, cp0_waddr_o, cp0_data_o, flush_o, busy_o, redirect_o, new_pc_o, exc_code_o} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_outputs: got we=%b addr=%0d data=%h flush=%b busy=%b redir=%b pc=%h code=%0d, want all 0",
               cp0_we_o, cp0_waddr_o, cp0_data_o, flush_o, busy_o, redirect_o, new_pc_o, exc_code_o);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    drive(1'b1, 32'h0000_0800, 32'h100, 1'b0, 6'd0, 1'b0, 32'h0000_FC01, 32'h0, 32'h1234);
    run_event(1'b1);
    n_checks++;
    if ({obs_we[1], obs_addr[1], obs_data[1]} !== {1'b1, 5'd5, 32'h100}) begin
      n_errors++;
      $display("[TB] FAIL ovf_epc: got we=%b addr=%0d data=%h, want 1 5 00000100", obs_we[1], obs_addr[1], obs_data[1]);
    end
    n_checks++;
    if ({obs_we[2], obs_addr[2], obs_data[2][6:2]} !== {1'b1, 5'd4, 5'd12}) begin
      n_errors++;
      $display("[TB] FAIL ovf_cause: got we=%b addr=%0d data=%h, want we=1 addr=4 code=12", obs_we[2], obs_addr[2], obs_data[2]);
    end
    n_checks++;
    if ({obs_we[3], obs_addr[3], obs_data[3]} !== {1'b1, 5'd3, 32'h0000_FC03}) begin
      n_errors++;
      $display("[TB] FAIL ovf_status: got we=%b addr=%0d data=%h, want 1 3 0000fc03", obs_we[3], obs_addr[3], obs_data[3]);
    end
    n_checks++;
    if ({obs_redir[3], obs_redir[4], obs_we[4], obs_pc[4], obs_busy[5], obs_code[1]} !== {1'b0, 1'b1, 1'b0, 32'h20, 1'b0, 5'd12}) begin
      n_errors++;
      $display("[TB] FAIL ovf_redirect: got r3=%b r4=%b we4=%b pc=%h busy5=%b code=%0d, want 0 1 0 00000020 0 12",
               obs_redir[3], obs_redir[4], obs_we[4], obs_pc[4], obs_busy[5], obs_code[1]);
    end
  endtask

  task automatic test_delay_slot_syscall;
    drive(1'b1, 32'h0000_0100, 32'h204, 1'b1, 6'd0, 1'b0, 32'h0000_0001, 32'h0, 32'h0);
    run_event(1'b1);
    n_checks++;
    if ({obs_data[1], obs_data[2][31], obs_data[2][6:2], obs_code[1]} !== {32'h200, 1'b1, 5'd8, 5'd8}) begin
      n_errors++;
      $display("[TB] FAIL ds_syscall: got epc=%h cause=%h code=%0d, want epc=00000200 bd=1 code=8",
               obs_data[1], obs_data[2], obs_code[1]);
    end
  endtask

  task automatic test_timer_interrupt;
    drive(1'b1, 32'h0000_0100, 32'h300, 1'b0, 6'd0, 1'b1, 32'h0000_8001, 32'h0, 32'h0);
    run_event(1'b1);
    n_checks++;
    if ({obs_code[1], obs_data[2][15], obs_data[2][6:2], obs_data[1]} !== {5'd0, 1'b1, 5'd0, 32'h300}) begin
      n_errors++;
      $display("[TB] FAIL timer_int: got code=%0d cause=%h epc=%h, want code=0 ip7=1 epc=00000300",
               obs_code[1], obs_data[2], obs_data[1]);
    end
  endtask

  task automatic test_masked_interrupt;
    logic [31:0] sts [2];
    sts[0] = 32'h0000_8003;
    sts[1] = 32'h0000_0001;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0, 32'h400, 1'b0, 6'd0, 1'b1, sts[i], 32'h0, 32'h0);
      run_event(1'b0);
      n_checks++;
      if ({obs_busy[1], obs_busy[2], obs_flush[1], obs_we[1], obs_pc[1]} !== {4'b0000, 32'h20}) begin
        n_errors++;
        $display("[TB] FAIL masked_int%0d: got busy=%b%b flush=%b we=%b pc=%h, want 0 0 0 0 00000020",
                 i, obs_busy[1], obs_busy[2], obs_flush[1], obs_we[1], obs_pc[1]);
      end
    end
  endtask

  task automatic test_eret;
    drive(1'b1, 32'h0000_1000, 32'h500, 1'b0, 6'd0, 1'b0, 32'h0000_0003, 32'h0, 32'h100);
    run_event(1'b1);
    n_checks++;
    if ({obs_we[1], obs_addr[1], obs_data[1], obs_redir[1]} !== {1'b1, 5'd3, 32'h1, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL eret_status: got we=%b addr=%0d data=%h redir=%b, want 1 3 00000001 0",
               obs_we[1], obs_addr[1], obs_data[1], obs_redir[1]);
    end
    n_checks++;
    if ({obs_redir[2], obs_we[2], obs_pc[2], obs_busy[3], obs_redir[3]} !== {1'b1, 1'b0, 32'h100, 1'b0, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL eret_redirect: got r2=%b we2=%b pc=%h busy3=%b r3=%b, want 1 0 00000100 0 0",
               obs_redir[2], obs_we[2], obs_pc[2], obs_busy[3], obs_redir[3]);
    end
  endtask

  task automatic test_nested_exl;
    drive(1'b1, 32'h0000_0800, 32'h600, 1'b0, 6'd0, 1'b0, 32'h0000_0003, 32'h8000_0000, 32'h0);
    run_event(1'b1);
    n_checks++;
    if ({obs_busy[1], obs_we[1], obs_data[2][31], obs_data[3], obs_redir[4]} !== {1'b1, 1'b0, 1'b1, 32'h3, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL nested_exl: got busy1=%b we1=%b cause=%h status=%h r4=%b, want 1 0 bd=1 00000003 1",
               obs_busy[1], obs_we[1], obs_data[2], obs_data[3], obs_redir[4]);
    end
  endtask

  task automatic test_reset_mid_sequence;
    drive(1'b1, 32'h0000_0200, 32'h700, 1'b0, 6'd0, 1'b0, 32'h0000_0001, 32'h0, 32'h0);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cp0_we_o, cp0_waddr_o} !== {1'b1, 5'd4}) begin
      n_errors++;
      $display("[TB] FAIL rstmid_precond: got we=%b addr=%0d, want 1 4", cp0_we_o, cp0_waddr_o);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cp0_we_o, cp0_waddr_o, cp0_data_o, flush_o, busy_o, redirect_o, new_pc_o, exc_code_o} !== '0) begin
      n_errors++;
      $display("[TB] FAIL rstmid_outputs: got we=%b addr=%0d data=%h flush=%b busy=%b redir=%b pc=%h code=%0d, want all 0",
               cp0_we_o, cp0_waddr_o, cp0_data_o, flush_o, busy_o, redirect_o, new_pc_o, exc_code_o);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy_o, cp0_we_o, redirect_o} !== 3'b000) begin
      n_errors++;
      $display("[TB] FAIL rstmid_idle: got busy=%b we=%b redir=%b, want 0 0 0", busy_o, cp0_we_o, redirect_o);
    end
  endtask

  // Reference model: classify the event from the architectural rules, then
  // list the CP0 writes and redirect cycle that sequence must produce.
  task automatic test_random;
    logic [31:0] m_pc = 32'h0;
    logic [4:0]  m_code = 5'd0;
    bit          code_known = 1'b1;
    int          codes [4] = '{8, 10, 13, 12};
    for (int t = 0; t < 60; t++) begin
      logic        v, bd, tmr, ev, eret, pend, exl;
      logic [31:0] et, pc, st, ca, ep, cdat;
      logic [5:0]  intl, ip;
      logic [4:0]  code;
      int          n;
      logic        ew [1:5];
      logic [4:0]  ea [1:5];
      logic [31:0] ed [1:5];
      v = ($urandom_range(0, 7) != 0);
      et = $urandom;
      et[12:8] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) et[12:8] = 5'd0;
      pc = $urandom; bd = 1'($urandom); intl = 6'($urandom); tmr = 1'($urandom);
      st = $urandom; st[0] = ($urandom_range(0, 3) != 0); st[1] = ($urandom_range(0, 3) == 0);
      ca = $urandom; ep = $urandom;
      ip = {intl[5] | tmr, intl[4:0]};
      exl = st[1];
      pend = ((ip & st[15:10]) != 6'd0) && st[0] && !exl;
      ev = 1'b0; eret = 1'b0; code = 5'd0;
      if (pend) ev = 1'b1;
      else begin
        for (int b = 0; b < 4; b++)
          if (!ev && et[8 + b]) begin ev = 1'b1; code = 5'(codes[b]); end
        if (!ev && et[12]) begin ev = 1'b1; eret = 1'b1; end
      end
      for (int k = 1; k <= 5; k++) begin ew[k] = 1'b0; ea[k] = 5'd0; ed[k] = 32'd0; end
      n = 0;
      if (v && ev) begin
        if (eret) begin
          n = 2;
          ew[1] = 1'b1; ea[1] = 5'd3; ed[1] = st & ~32'h2;
          m_pc = ep; code_known = 1'b0;
        end else begin
          n = 4;
          if (!exl) begin ew[1] = 1'b1; ea[1] = 5'd5; ed[1] = bd ? pc - 32'd4 : pc; end
          cdat = ca; cdat[15:10] = ip; cdat[6:2] = code;
          if (!exl) cdat[31] = bd;
          ew[2] = 1'b1; ea[2] = 5'd4; ed[2] = cdat;
          ew[3] = 1'b1; ea[3] = 5'd3; ed[3] = st | 32'h2;
          m_pc = 32'h20; m_code = code; code_known = 1'b1;
        end
      end
      drive(v, et, pc, bd, intl, tmr, st, ca, ep);
      run_event(v && ev);
      for (int k = 1; k <= 5; k++) begin
        logic eb;
        eb = (k <= n);
        n_checks++;
        if ({obs_busy[k], obs_flush[k], obs_redir[k], obs_we[k], obs_addr[k], obs_data[k]} !==
            {eb, eb, (k == n), ew[k], ea[k], ed[k]}) begin
          n_errors++;
          $display("[TB] FAIL rand%0d_cycle%0d: got busy=%b flush=%b redir=%b we=%b addr=%0d data=%h, want %b %b %b %b %0d %h",
                   t, k, obs_busy[k], obs_flush[k], obs_redir[k], obs_we[k], obs_addr[k], obs_data[k],
                   eb, eb, (k == n), ew[k], ea[k], ed[k]);
        end
      end
      n_checks++;
      if (obs_pc[1] !== m_pc || (code_known && obs_code[1] !== m_code)) begin
        n_errors++;
        $display("[TB] FAIL rand%0d_pc_code: got pc=%h code=%0d, want pc=%h code=%0d (code checked=%b)",
                 t, obs_pc[1], obs_code[1], m_pc, m_code, code_known);
      end
    end
  endtask

  initial begin
    test_reset;
    test_overflow;
    test_delay_slot_syscall;
    test_timer_interrupt;
    test_masked_interrupt;
    test_eret;
    test_nested_exl;
    test_reset_mid_sequence;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
